multimode_ff_bank: RTL and testbench



---
 rtl/ff_bank_pkg.sv | 37 +++
 rtl/ff_cell.sv | 46 ++++
 rtl/multimode_ff_bank.sv | 45 ++++
 tb/tb_multimode_ff_bank.sv | 116 +++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared mode encodings and the per-bit next-state rule for the multimode flip-flop bank.
package ff_bank_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // a is D/T/J/S, b is K/R; S=R=1 holds (the error flag is raised elsewhere)
  function automatic logic ff_next(input logic [1:0] mode, input logic q,
                                   input logic a, input logic b);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_D:  nxt = a;
      MODE_T:  nxt = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One channel of the bank: stored bit, registered change pulse and sticky S=R=1 error flag.
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       ce,
  input  logic       a,
  input  logic       b,
  input  logic       load,
  input  logic       load_val,
  input  logic       err_clr,
  input  logic       rst_val,
  output logic       q,
  output logic       changed,
  output logic       sr_err
);

  logic q_next;
  logic sr_viol;

  always_comb begin
    q_next = q;
    if (load)
      q_next = load_val;
    else if (ce)
      q_next = ff_next(mode, q, a, b);
  end

  assign sr_viol = !load && ce && (mode == MODE_SR) && a && b;

  // A new violation outranks a simultaneous clear so no event is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= rst_val;
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
      sr_err  <= sr_viol | (sr_err & ~err_clr);
    end
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH independent D/T/JK/SR flip-flops sharing a clock and a bank-wide mode select.
module multimode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] CE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_N,
  output logic [WIDTH-1:0] CHANGED,
  output logic [WIDTH-1:0] SR_ERR
);

  localparam logic [WIDTH-1:0] RST_BITS = RESET_VAL;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk      (CLK),
      .reset    (RESET),
      .mode     (MODE),
      .ce       (CE[i]),
      .a        (A[i]),
      .b        (B[i]),
      .load     (LOAD),
      .load_val (LOAD_VAL[i]),
      .err_clr  (ERR_CLR),
      .rst_val  (RST_BITS[i]),
      .q        (Q[i]),
      .changed  (CHANGED[i]),
      .sr_err   (SR_ERR[i])
    );
  end

  assign Q_N = ~Q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed checks of the multimode flip-flop bank with hand-computed expected values.
module tb_multimode_ff_bank;
  import ff_bank_pkg::*;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] CE, A, B, LOAD_VAL;
  logic             LOAD, ERR_CLR;
  logic [WIDTH-1:0] Q, Q_N, CHANGED, SR_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  multimode_ff_bank #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MODE     (MODE),
    .CE       (CE),
    .A        (A),
    .B        (B),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .ERR_CLR  (ERR_CLR),
    .Q        (Q),
    .Q_N      (Q_N),
    .CHANGED  (CHANGED),
    .SR_ERR   (SR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_qc(input string tag, input logic [7:0] q_exp, input logic [7:0] ch_exp);
    check({tag, "_q"}, Q, q_exp);
    check({tag, "_changed"}, CHANGED, ch_exp);
  endtask

  initial begin
    RESET = 1'b1; LOAD = 1'b1; LOAD_VAL = 8'hFF; MODE = MODE_D;
    CE = 8'h00; A = 8'h00; B = 8'h00; ERR_CLR = 1'b0;
    step(); step();
    check("rst_q", Q, 8'hA5);
    check("rst_qn", Q_N, 8'h5A);
    check("rst_changed", CHANGED, 8'h00);
    check("rst_srerr", SR_ERR, 8'h00);

    RESET = 1'b0; LOAD = 1'b1; LOAD_VAL = 8'h00;
    step(); expect_qc("load0", 8'h00, 8'hA5);

    LOAD = 1'b0; MODE = MODE_T; CE = 8'hFF; A = 8'h0F;
    step(); expect_qc("t1", 8'h0F, 8'h0F);
    step(); expect_qc("t2", 8'h00, 8'h0F);
    step(); expect_qc("t3", 8'h0F, 8'h0F);
    check("t3_qn", Q_N, 8'hF0);

    RESET = 1'b1; LOAD = 1'b1; LOAD_VAL = 8'hFF;
    step(); expect_qc("midrst", 8'hA5, 8'h00);
    RESET = 1'b0; LOAD = 1'b0;
    step(); expect_qc("resume", 8'hAA, 8'h0F);

    LOAD = 1'b1; LOAD_VAL = 8'h00;
    step(); expect_qc("jk_pre", 8'h00, 8'hAA);
    LOAD = 1'b0; MODE = MODE_JK; A = 8'hF0; B = 8'hCC;
    step(); expect_qc("jk1", 8'hF0, 8'hF0);
    step(); expect_qc("jk2", 8'h30, 8'hC0);

    MODE = MODE_SR; CE = 8'h01; A = 8'h01; B = 8'h00;
    step(); expect_qc("sr_set", 8'h31, 8'h01);
    check("sr_set_err", SR_ERR, 8'h00);
    A = 8'h01; B = 8'h01; ERR_CLR = 1'b1;
    step(); expect_qc("sr_viol", 8'h31, 8'h00);
    check("sr_viol_err", SR_ERR, 8'h01);
    A = 8'h00; B = 8'h00;
    step(); check("sr_clr_err", SR_ERR, 8'h00);
    check("sr_clr_q", Q, 8'h31);
    ERR_CLR = 1'b0; CE = 8'h00; A = 8'hFF; B = 8'hFF;
    step(); check("sr_ce0_err", SR_ERR, 8'h00);
    check("sr_ce0_q", Q, 8'h31);
    CE = 8'h01; A = 8'h00; B = 8'h01;
    step(); expect_qc("sr_rst", 8'h30, 8'h01);
    CE = 8'hFF; A = 8'h0C; B = 8'h30;
    step(); expect_qc("sr_mix", 8'h0C, 8'h3C);

    MODE = MODE_D; CE = 8'h00; A = 8'hFF; B = 8'h00;
    step(); expect_qc("ce0_hold", 8'h0C, 8'h00);
    LOAD = 1'b1; LOAD_VAL = 8'h3C;
    step(); expect_qc("load_ce0", 8'h3C, 8'h30);
    LOAD = 1'b0; CE = 8'hF0; A = 8'hA5;
    step(); expect_qc("d_part", 8'hAC, 8'h90);

    MODE = MODE_SR; CE = 8'hFF; A = 8'hFF; B = 8'hFF; LOAD = 1'b1; LOAD_VAL = 8'h00;
    step(); expect_qc("load_sr", 8'h00, 8'hAC);
    check("load_sr_err", SR_ERR, 8'h00);
    check("load_sr_qn", Q_N, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
